// File: rtl/mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// mod_counter_pkg
//   Shared constants and helpers for the mod_counter block.
//   - COUNT_UP / COUNT_DOWN : encoding of the 'up' direction input.
//   - prescale_width()      : bit width needed to hold a prescaler count
//                             in the range 0..PRESCALE-1 (never less than 1).
// -----------------------------------------------------------------------------
package mod_counter_pkg;

  localparam logic COUNT_UP   = 1'b1;
  localparam logic COUNT_DOWN = 1'b0;

  // Width of a counter that runs 0..prescale-1. A one-bit register is kept
  // even for prescale=1 so the prescaler never collapses to a zero-width
  // vector.
  function automatic int prescale_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage : mod_counter_pkg

// File: rtl/mod_counter_prescaler.sv
// -----------------------------------------------------------------------------
// mod_counter_prescaler
//   Divides the enable stream: 'tick' is high in every PRESCALE-th cycle in
//   which 'en' is high. The internal count only advances while en=1 and is
//   forced to zero by 'clear' or 'reset'.
//
// Parameters
//   PRESCALE : enabled cycles per tick (1..65535); PRESCALE=1 gives tick=en.
// Ports
//   clock : rising-edge clock
//   reset : synchronous, active-high reset
//   en    : count enable
//   clear : synchronous clear of the count (takes priority over en)
//   tick  : combinational tick, valid in the cycle it is consumed
// -----------------------------------------------------------------------------
module mod_counter_prescaler
  import mod_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int PW = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] count;

  // Tick fires in the enabled cycle that would move the count past LAST.
  // With PRESCALE=1 the count is pinned at 0 == LAST, so tick follows en.
  assign tick = en && (count == LAST);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + PW'(1);
    end
  end

endmodule : mod_counter_prescaler

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//   Up/down modulo-MODULUS counter with an enable prescaler, synchronous load
//   (clamped to MODULUS-1) and a registered terminal-count pulse.
//   Priority per edge: reset > load > tick > hold.
//
//   Optional feature: define MOD_COUNTER_SAT_EN to add the 'sat' input. With
//   sat=1 the counter holds at MODULUS-1 (up) or 0 (down) instead of wrapping,
//   and tc pulses once on the tick that reaches that bound.
//
// Parameters
//   WIDTH    : counter width in bits (1..32)
//   MODULUS  : count range 0..MODULUS-1 (2..2^WIDTH)
//   PRESCALE : enabled cycles per count step (1..65535)
// Ports
//   clock      : rising-edge clock
//   reset      : synchronous, active-high reset
//   en         : count enable (gates prescaler and counter)
//   up         : direction, COUNT_UP = increment, COUNT_DOWN = decrement
//   load       : synchronous load strobe
//   load_value : value to load
//   value      : registered count
//   tc         : registered terminal-count pulse
//   sat        : (MOD_COUNTER_SAT_EN only) saturate instead of wrapping
// -----------------------------------------------------------------------------
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MODULUS  = 256,
  parameter int              PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             tc
`ifdef MOD_COUNTER_SAT_EN
  ,
  input  logic             sat
`endif
);

  // Top of the count range. Computed in 64-bit arithmetic before narrowing,
  // so MODULUS = 2^WIDTH yields all-ones rather than a truncated zero.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  logic             tick;
  logic             sat_on;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] next_value;
  logic             next_tc;

`ifdef MOD_COUNTER_SAT_EN
  assign sat_on = sat;
`else
  assign sat_on = 1'b0;
`endif

  mod_counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .en    (en),
    .clear (load),
    .tick  (tick)
  );

  // Out-of-range load values are clamped to the top of the range.
  assign load_clamped = (64'(load_value) >= MODULUS) ? MAX_VAL : load_value;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    next_value = value;
    next_tc    = 1'b0;
    if (load) begin
      next_value = load_clamped;
    end else if (tick) begin
      case (up)
        COUNT_UP: begin
          if (value == MAX_VAL) begin
            if (!sat_on) begin
              next_value = '0;
              next_tc    = 1'b1;
            end
          end else begin
            next_value = value + WIDTH'(1);
            // In saturating mode the pulse marks arrival at the bound.
            next_tc    = sat_on && (next_value == MAX_VAL);
          end
        end
        COUNT_DOWN: begin
          if (value == '0) begin
            if (!sat_on) begin
              next_value = MAX_VAL;
              next_tc    = 1'b1;
            end
          end else begin
            next_value = value - WIDTH'(1);
            next_tc    = sat_on && (next_value == '0);
          end
        end
        default: begin
          next_value = value;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      value <= '0;
      tc    <= 1'b0;
    end else begin
      value <= next_value;
      tc    <= next_tc;
    end
  end

endmodule : mod_counter

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (1..32).
REQ-002 SHALL have parameter MODULUS, default 256, count range 0..MODULUS-1 (2..2^WIDTH).
REQ-003 SHALL have parameter PRESCALE, default 1, enabled cycles per count step (1..65535).
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en  input  1  count enable; gates prescaler and counter.
REQ-007 SHALL have port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 SHALL have port load  input  1  synchronous load strobe.
REQ-009 SHALL have port load_value  input  WIDTH  value to load.
REQ-010 SHALL have port value  output  WIDTH  registered count.
REQ-011 SHALL have port tc  output  1  registered terminal-count pulse.

Function
REQ-012 SHALL assert internal tick in a cycle where en=1 and the prescaler is at PRESCALE-1; with PRESCALE=1, tick equals en.
REQ-013 SHALL advance the prescaler only while en=1, wrapping from PRESCALE-1 to 0; en=0 holds it.
REQ-014 SHALL priority-order: reset > load > tick > hold.
REQ-015 SHALL on load set value to load_value, or to MODULUS-1 if load_value >= MODULUS, on the next edge.
REQ-016 SHALL clear the prescaler on load; en and up are ignored in that cycle; tc=0 after the load edge.
REQ-017 SHALL on tick with up=1 step value+1; from MODULUS-1 wrap to 0.
REQ-018 SHALL on tick with up=0 step value-1; from 0 wrap to MODULUS-1.
REQ-019 SHALL assert tc for exactly one cycle, coincident with the wrapped value; tc=0 otherwise.
REQ-020 SHALL have latency of one edge from sampled tick/load to updated value and tc.
REQ-021 SHALL honour a direction change on any tick with no extra latency or skipped value.
REQ-022 SHALL hold value, prescaler and tc=0 when en=0 and load=0.
REQ-023 SHALL compute arithmetic at WIDTH bits with no truncation artefacts when MODULUS=2^WIDTH.

Reset
REQ-024 SHALL on reset=1 at an edge set value=0, tc=0, prescaler=0, including mid-prescale and concurrent with load.
REQ-025 SHALL resume counting from 0 on the first eligible tick after reset deasserts.

Configuration
REQ-026 SHALL, when macro MOD_COUNTER_SAT_EN is defined, add port sat  input  1; sat=1 makes the counter hold at MODULUS-1 (up) or 0 (down) instead of wrapping.
REQ-027 SHALL, with MOD_COUNTER_SAT_EN and sat=1, assert tc on the single tick that reaches the bound and keep tc=0 while held there.
REQ-028 SHALL, without MOD_COUNTER_SAT_EN, have no sat port and always wrap.

Structure
REQ-029 SHALL place the direction encoding constants (COUNT_UP, COUNT_DOWN) and the PRESCALE width function in shared package mod_counter_pkg.
REQ-030 SHALL implement the prescaler as sub-module mod_counter_prescaler (ports clock, reset, en, clear, tick).

Verification
REQ-031 SHALL cover WIDTH=8, MODULUS=10, PRESCALE=1, up=1, en=1 from reset: value 0..9, 0; tc high only with value=0 after 9.
REQ-032 SHALL cover down count from load_value=2, MODULUS=10: value 2,1,0,9; tc high only with 9.
REQ-033 SHALL cover PRESCALE=4, en=1: value steps once per 4 cycles; en=0 for 3 cycles mid-prescale extends the interval to 7.
REQ-034 SHALL cover load_value=200 with MODULUS=100 -> value=99; load and reset in the same cycle -> value=0.
REQ-035 SHALL cover MODULUS=256, WIDTH=8: 255 up -> 0 with tc; 0 down -> 255 with tc.
REQ-036 SHALL cover, with MOD_COUNTER_SAT_EN and sat=1, MODULUS=10 counting up from 8: value 9,9,9; tc high once at the first 9.
